// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants used by the register file and its writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned AddrW   = 5;
  localparam int unsigned DataW   = 32;
  localparam int unsigned NumRegs = 32;

  // Register 0 is hardwired; writes to it are swallowed.
  localparam logic [AddrW-1:0] ZeroReg = '0;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin grant over NReq requesters; the pointer moves just past the last winner.
module rr_arbiter #(
  parameter int unsigned NReq = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NReq-1:0] valid_i,
  output logic [NReq-1:0] grant_o
);

  localparam int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     idx;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NReq; i++) begin
      idx = (32'(ptr_q) + i) % NReq;
      if (!found && valid_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_d        = (idx == NReq - 1) ? '0 : IdxW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: picks one requester per cycle, registers the register-file write,
// and tracks which registers have a reserved-but-uncommitted write in a busy scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = AddrW,
  parameter int unsigned DW   = DataW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic               rsv_en_i,
  input  logic [AW-1:0]      rsv_addr_i,
  output logic               wr_en_o,
  output logic [AW-1:0]      wr_addr_o,
  output logic [DW-1:0]      wr_data_o,
  output logic [NumRegs-1:0] busy_o
);

  logic [NREQ-1:0]    grant;
  logic               xfer;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  logic               wr_en_q;
  logic [AW-1:0]      wr_addr_q;
  logic [DW-1:0]      wr_data_q;
  logic [NumRegs-1:0] busy_q, busy_d;

  rr_arbiter #(
    .NReq (NREQ)
  ) u_rr_arbiter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (req_valid_i),
    .grant_o (grant)
  );

  assign req_ready_o = grant & {NREQ{rst_ni}};
  assign xfer        = |req_ready_o;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_addr_i[i*AW +: AW];
        sel_data = sel_data | req_data_i[i*DW +: DW];
      end
    end
  end

  // Reserve is applied after commit so a same-cycle collision leaves the register busy.
  always_comb begin
    busy_d = busy_q;
    if (xfer) begin
      busy_d[sel_addr] = 1'b0;
    end
    if (rsv_en_i) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q <= xfer && (sel_addr != AW'(ZeroReg));
      if (xfer) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
      busy_q <= busy_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = busy_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of writeback requesters.
REQ-002 Parameter AW, default 5: register address width, 32 registers.
REQ-003 Parameter DW, default 32: register data width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  NREQ  per-requester writeback request.
REQ-007 req_addr  in  NREQ*AW  per-requester destination register.
REQ-008 req_data  in  NREQ*DW  per-requester writeback data.
REQ-009 req_ready  out  NREQ  one-hot grant; a request transfers when valid and ready are both high.
REQ-010 rsv_en  in  1  issue stage reserves a destination register.
REQ-011 rsv_addr  in  AW  register being reserved.
REQ-012 wr_en  out  1  register-file write enable.
REQ-013 wr_addr  out  AW  register-file write address.
REQ-014 wr_data  out  DW  register-file write data.
REQ-015 busy  out  32  scoreboard; bit r high means register r has a write pending.

Function
REQ-016 req_ready shall be combinational from req_valid and the round-robin pointer, with at most one bit high, and never high for a requester whose valid is low.
REQ-017 Arbitration is round-robin: search starts at pointer index and wraps modulo NREQ; the first valid requester is granted.
REQ-018 After a grant to index g, the pointer becomes (g+1) mod NREQ; with no grant, the pointer holds.
REQ-019 Granted request is registered: wr_en/wr_addr/wr_data reflect it exactly one cycle after the transfer. Latency is fixed at 1 with no back-pressure from the register file.
REQ-020 A cycle with no transfer drives wr_en low on the next cycle; wr_addr/wr_data hold their last values.
REQ-021 A granted write to address 0 is accepted (ready high) but drives wr_en low; register 0 is never written.
REQ-022 busy[r] is set the cycle after rsv_en with rsv_addr=r, r!=0; a reserve of address 0 is ignored; busy[0] is constantly 0.
REQ-023 busy[r] is cleared the cycle after a transfer with req_addr=r (commit at the same edge wr_en rises).
REQ-024 If a reserve and a commit hit the same register on the same cycle, the reserve wins and busy stays set.
REQ-025 A reserve of an already-busy register leaves it set; there is no reservation count.
REQ-026 A commit to a non-busy register is legal; the write occurs and busy stays 0.
REQ-027 Requesters hold req_addr/req_data stable while valid is high and not ready; the block does not check this.

Reset
REQ-028 While rst_n is low: wr_en=0, wr_addr=0, wr_data=0, busy=0, pointer=0 (requester 0 highest priority).
REQ-029 Assertion mid-operation discards any registered write immediately: wr_en drops asynchronously and no write is issued after release.
REQ-030 req_ready is combinational and is forced to 0 while rst_n is low.

Structure
REQ-031 A shared package holds the AW/DW defaults, the register count (32), and the zero-register address constant used by both the register file and this block.
REQ-032 One sub-module, rr_arbiter (NREQ-wide round-robin grant with pointer update), is instantiated once; scoreboard and output registers stay in the top level.

Verification
REQ-033 All three valid continuously after reset: grants 0,1,2,0,1,2 on consecutive cycles; wr_en high every cycle from cycle 2 onward.
REQ-034 Only requester 2 valid, addr 7, data 0xDEADBEEF: ready[2]=1 the same cycle; next cycle wr_en=1, wr_addr=7, wr_data=0xDEADBEEF; pointer becomes 0.
REQ-035 Requester 1 writes addr 0, data 0x1234: ready[1]=1; next cycle wr_en=0; busy stays all-zero.
REQ-036 Reserve addr 5, then a commit to 5 three cycles later: busy[5]=1 from the cycle after the reserve until the cycle after the commit, then 0.
REQ-037 Reserve addr 9 and commit addr 9 on the same cycle with busy[9]=1: busy[9] remains 1 and the write to 9 still occurs.
REQ-038 rst_n pulsed low on the cycle after a transfer: wr_en=0 during reset; busy=0, pointer=0; first post-release grant goes to the lowest valid index.
